// File: rtl/wb_xbar_pkg.sv
// ============================================================================
// Module   : wb_xbar_pkg
// Purpose  : Shared types, default address map and decode helper for wb_xbar_rr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_xbar_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } xbar_state_t;

    localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
    localparam logic [31:0] RAM_BASE    = 32'h1000_0000;
    localparam logic [31:0] RAM2_BASE   = 32'h2000_0000;
    localparam logic [31:0] IO_BASE     = 32'h3000_0000;
    localparam logic [31:0] REGION_MASK = 32'hF000_0000;

    // Operands are zero-extended to 64 bits so one helper serves any AW up to 64.
    function automatic logic addr_hit(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// Module   : wb_rr_arbiter
// Purpose  : Round-robin request picker with a last-winner pointer register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_arbiter #(
    parameter int NM = 3,
    localparam int IW = $clog2(NM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NM-1:0] req,
    input  logic          release_en,
    input  logic [IW-1:0] release_idx,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] last;

    // Scan last+1, last+2, ... so the previous winner is considered last.
    always_comb begin : p_pick
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NM; k++) begin
            idx = (int'(last) + k) % NM;
            if (!grant_valid && req[IW'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IW'(NM - 1);
        end else if (release_en) begin
            last <= release_idx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_xbar_rr.sv
// ============================================================================
// Module   : wb_xbar_rr
// Purpose  : Round-robin arbitrated Wishbone shared bus with address decode,
//            bus locking and error response. Optional macro WB_XBAR_TIMEOUT_EN
//            adds a stalled-slave timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_xbar_rr
    import wb_xbar_pkg::*;
#(
    parameter int               NM       = 3,
    parameter int               NS       = 4,
    parameter int               AW       = 32,
    parameter int               DW       = 32,
    parameter logic [NS*AW-1:0] SLV_BASE = {IO_BASE, RAM2_BASE, RAM_BASE, ROM_BASE},
    parameter logic [NS*AW-1:0] SLV_MASK = {4{REGION_MASK}},
    parameter int               TIMEOUT  = 255,
    localparam int              SW       = DW / 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM*SW-1:0] m_sel_i,
    input  logic [NM*AW-1:0] m_addr_i,
    input  logic [NM*DW-1:0] m_data_i,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [DW-1:0]    m_data_o,
    output logic [NS-1:0]    s_stb_o,
    output logic             s_we_o,
    output logic [SW-1:0]    s_sel_o,
    output logic [AW-1:0]    s_addr_o,
    output logic [DW-1:0]    s_data_o,
    input  logic [NS-1:0]    s_ack_i,
    input  logic [NS*DW-1:0] s_data_i
);

    localparam int IW  = $clog2(NM);
    localparam int SIW = (NS > 1) ? $clog2(NS) : 1;

    if (NM < 2 || NM > 8 || NS < 1 || NS > 8 || AW > 64 || (DW % 8) != 0 ||
        TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("wb_xbar_rr: unsupported parameter set");
    end

    xbar_state_t   state, state_nx;
    logic [IW-1:0] grant, grant_nx;
    logic          arb_valid;
    logic [IW-1:0] arb_idx;
    logic          busy, release_en, active, to_fire;

    logic          g_cyc, g_stb, g_we;
    logic [SW-1:0] g_sel;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;

    logic [NS-1:0]  hit, sel_oh;
    logic [SIW-1:0] sel_idx;
    logic           any_hit;

    wb_rr_arbiter #(
        .NM (NM)
    ) u_arb (
        .clk         (sys_clk),
        .rst_n       (sys_rst),
        .req         (m_cyc_i & m_stb_i),
        .release_en  (release_en),
        .release_idx (grant),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    always_comb begin
        g_cyc   = m_cyc_i[grant];
        g_stb   = m_stb_i[grant];
        g_we    = m_we_i[grant];
        g_sel   = m_sel_i[grant*SW +: SW];
        g_addr  = m_addr_i[grant*AW +: AW];
        g_wdata = m_data_i[grant*DW +: DW];
    end

    assign busy       = (state == BUSY);
    assign release_en = busy && !g_cyc;
    assign active     = busy && g_cyc && g_stb;

    for (genvar i = 0; i < NS; i++) begin : g_decode
        assign hit[i] = addr_hit(64'(g_addr), 64'(SLV_BASE[i*AW +: AW]),
                                 64'(SLV_MASK[i*AW +: AW]));
    end

    // Overlapping regions resolve to the lowest slave index.
    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        any_hit = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (!any_hit && hit[i]) begin
                any_hit    = 1'b1;
                sel_oh[i]  = 1'b1;
                sel_idx    = SIW'(i);
            end
        end
    end

`ifdef WB_XBAR_TIMEOUT_EN
    localparam int TW = 16;
    logic [TW-1:0] to_cnt;

    assign to_fire = active && (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            to_cnt <= '0;
        end else if (active && any_hit && !s_ack_i[sel_idx] && !to_fire) begin
            to_cnt <= to_cnt + TW'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
        end
    end

    // Grant is held while the owner keeps cyc high, which gives bus locking.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nx = BUSY;
                    grant_nx = arb_idx;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        m_ack_o  = '0;
        m_err_o  = '0;
        m_data_o = '0;
        s_stb_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        if (busy) begin
            s_we_o   = g_we;
            s_sel_o  = g_sel;
            s_addr_o = g_addr;
            s_data_o = g_wdata;
            if (any_hit) begin
                m_data_o = s_data_i[sel_idx*DW +: DW];
            end
            if (to_fire) begin
                m_err_o[grant] = 1'b1;
            end else if (active) begin
                s_stb_o = sel_oh;
                if (any_hit) begin
                    m_ack_o[grant] = s_ack_i[sel_idx];
                end else begin
                    m_err_o[grant] = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_xbar_rr.sv
// ============================================================================
// Module   : tb_wb_xbar_rr
// Purpose  : Directed table-driven bench for wb_xbar_rr plus abort/reset/stall
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_xbar_rr;

    localparam int NM = 3;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

`ifdef WB_XBAR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b0;
    logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [NM*SW-1:0] m_sel_i;
    logic [NM*AW-1:0] m_addr_i;
    logic [NM*DW-1:0] m_data_i;
    logic [NM-1:0]    m_ack_o, m_err_o;
    logic [DW-1:0]    m_data_o;
    logic [NS-1:0]    s_stb_o;
    logic             s_we_o;
    logic [SW-1:0]    s_sel_o;
    logic [AW-1:0]    s_addr_o;
    logic [DW-1:0]    s_data_o;
    logic [NS-1:0]    s_ack_i;
    logic [NS*DW-1:0] s_data_i;

    wb_xbar_rr #(
        .NM      (NM),
        .NS      (NS),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (8)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .m_cyc_i  (m_cyc_i),
        .m_stb_i  (m_stb_i),
        .m_we_i   (m_we_i),
        .m_sel_i  (m_sel_i),
        .m_addr_i (m_addr_i),
        .m_data_i (m_data_i),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .m_data_o (m_data_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_addr_o (s_addr_o),
        .s_data_o (s_data_o),
        .s_ack_i  (s_ack_i),
        .s_data_i (s_data_i)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [2:0]  cyc, stb, we;
        logic [31:0] a0, a1, a2;
        logic [3:0]  sack;
        logic [2:0]  e_ack, e_err;
        logic [3:0]  e_stb;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_addr, e_wdata, e_rdata;
    } vec_t;

    int n_run  = 0;
    int n_fail = 0;

    function automatic logic [110:0] outs();
        return {m_ack_o, m_err_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o, m_data_o};
    endfunction

    task automatic chk(input string name, input logic [110:0] act, input logic [110:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] c, input logic [2:0] s, input logic [2:0] w,
                                input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                                input logic [3:0] sack, input logic [3:0] e_stb,
                                input logic [2:0] e_ack, input logic [2:0] e_err, input logic e_we,
                                input logic [3:0] e_sel, input logic [31:0] e_addr,
                                input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        vec_t v;
        v = '{cyc: c, stb: s, we: w, a0: a0, a1: a1, a2: a2, sack: sack, e_ack: e_ack,
              e_err: e_err, e_stb: e_stb, e_we: e_we, e_sel: e_sel, e_addr: e_addr,
              e_wdata: e_wdata, e_rdata: e_rdata};
        return v;
    endfunction

    function automatic vec_t idle(input logic [2:0] c, input logic [2:0] s, input logic [2:0] w,
                                  input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
        return mk(c, s, w, a0, a1, a2, 4'h0, 4'h0, 3'b0, 3'b0, 1'b0, 4'h0, '0, '0, '0);
    endfunction

    task automatic drive(input logic [2:0] c, input logic [2:0] s, input logic [2:0] w,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [3:0] sack);
        m_cyc_i  = c;
        m_stb_i  = s;
        m_we_i   = w;
        m_addr_i = {a2, a1, a0};
        s_ack_i  = sack;
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    localparam logic [31:0] Z   = 32'h0;
    localparam logic [31:0] A0  = 32'h0000_0004;
    localparam logic [31:0] A1C = 32'h2000_0008;
    localparam logic [31:0] A2C = 32'h3000_000C;
    localparam logic [31:0] AS  = 32'h1000_0010;
    localparam logic [31:0] AU  = 32'hF000_0000;
    localparam logic [31:0] B   = 32'h3000_0000;
    localparam logic [31:0] W0  = 32'h0101_0101;
    localparam logic [31:0] W1  = 32'h1111_1111;
    localparam logic [31:0] W2  = 32'h2020_2020;
    localparam logic [31:0] D0  = 32'h0000_AAAA;
    localparam logic [31:0] D1  = 32'hDEAD_BEEF;
    localparam logic [31:0] D2  = 32'h2222_2222;
    localparam logic [31:0] D3  = 32'h3333_3333;

    vec_t vq[$];

    initial begin
        logic [3:0] e_stb;
        logic [2:0] e_err;

        m_sel_i  = {4'h1, 4'h3, 4'hF};
        m_data_i = {W2, W1, W0};
        s_data_i = {D3, D2, D1, D0};
        drive(3'b0, 3'b0, 3'b0, Z, Z, Z, 4'h0);

        repeat (2) @(posedge sys_clk);
        #1;
        chk("reset_outputs", outs(), '0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        step();

        // Contention: grant order 0,1,2,0 starting from last = NM-1.
        vq.push_back(idle(3'b111, 3'b111, 3'b010, A0, A1C, A2C));
        vq.push_back(mk(3'b111, 3'b111, 3'b010, A0, A1C, A2C, 4'b0001, 4'b0001, 3'b001, 3'b000, 1'b0, 4'hF, A0, W0, D0));
        vq.push_back(mk(3'b110, 3'b110, 3'b010, A0, A1C, A2C, 4'b0000, 4'b0000, 3'b000, 3'b000, 1'b0, 4'hF, A0, W0, D0));
        vq.push_back(idle(3'b111, 3'b111, 3'b010, A0, A1C, A2C));
        vq.push_back(mk(3'b111, 3'b111, 3'b010, A0, A1C, A2C, 4'b0100, 4'b0100, 3'b010, 3'b000, 1'b1, 4'h3, A1C, W1, D2));
        vq.push_back(mk(3'b101, 3'b101, 3'b010, A0, A1C, A2C, 4'b0000, 4'b0000, 3'b000, 3'b000, 1'b1, 4'h3, A1C, W1, D2));
        vq.push_back(idle(3'b111, 3'b111, 3'b010, A0, A1C, A2C));
        vq.push_back(mk(3'b111, 3'b111, 3'b010, A0, A1C, A2C, 4'b1000, 4'b1000, 3'b100, 3'b000, 1'b0, 4'h1, A2C, W2, D3));
        vq.push_back(mk(3'b011, 3'b011, 3'b010, A0, A1C, A2C, 4'b0000, 4'b0000, 3'b000, 3'b000, 1'b0, 4'h1, A2C, W2, D3));
        vq.push_back(idle(3'b111, 3'b111, 3'b010, A0, A1C, A2C));
        vq.push_back(mk(3'b111, 3'b111, 3'b010, A0, A1C, A2C, 4'b0001, 4'b0001, 3'b001, 3'b000, 1'b0, 4'hF, A0, W0, D0));
        vq.push_back(mk(3'b000, 3'b000, 3'b010, A0, A1C, A2C, 4'b0000, 4'b0000, 3'b000, 3'b000, 1'b0, 4'hF, A0, W0, D0));
        vq.push_back(idle(3'b000, 3'b000, 3'b000, Z, Z, Z));
        // Single master read; an ack from an unselected slave must be ignored.
        vq.push_back(idle(3'b001, 3'b001, 3'b000, AS, Z, Z));
        vq.push_back(mk(3'b001, 3'b001, 3'b000, AS, Z, Z, 4'b0000, 4'b0010, 3'b000, 3'b000, 1'b0, 4'hF, AS, W0, D1));
        vq.push_back(mk(3'b001, 3'b001, 3'b000, AS, Z, Z, 4'b0001, 4'b0010, 3'b000, 3'b000, 1'b0, 4'hF, AS, W0, D1));
        vq.push_back(mk(3'b001, 3'b001, 3'b000, AS, Z, Z, 4'b0010, 4'b0010, 3'b001, 3'b000, 1'b0, 4'hF, AS, W0, D1));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, AS, Z, Z, 4'b0000, 4'b0000, 3'b000, 3'b000, 1'b0, 4'hF, AS, W0, D1));
        vq.push_back(idle(3'b000, 3'b000, 3'b000, Z, Z, Z));
        // Unmapped address from m2.
        vq.push_back(idle(3'b100, 3'b100, 3'b000, Z, Z, AU));
        vq.push_back(mk(3'b100, 3'b100, 3'b000, Z, Z, AU, 4'b0000, 4'b0000, 3'b000, 3'b100, 1'b0, 4'h1, AU, W2, Z));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, Z, Z, AU, 4'b0000, 4'b0000, 3'b000, 3'b000, 1'b0, 4'h1, AU, W2, Z));
        vq.push_back(idle(3'b000, 3'b000, 3'b000, Z, Z, Z));
        // Locked burst of four writes by m1 while m0 keeps requesting.
        vq.push_back(idle(3'b010, 3'b010, 3'b010, Z, B, Z));
        for (int k = 0; k < 4; k++) begin
            vq.push_back(mk(3'b011, 3'b011, 3'b010, A0, B + 32'(4*k), Z, 4'b1000, 4'b1000, 3'b010, 3'b000, 1'b1, 4'h3, B + 32'(4*k), W1, D3));
        end
        vq.push_back(mk(3'b001, 3'b001, 3'b010, A0, B + 32'hC, Z, 4'b0000, 4'b0000, 3'b000, 3'b000, 1'b1, 4'h3, B + 32'hC, W1, D3));
        vq.push_back(idle(3'b001, 3'b001, 3'b010, A0, B + 32'hC, Z));
        vq.push_back(mk(3'b001, 3'b001, 3'b010, A0, Z, Z, 4'b0001, 4'b0001, 3'b001, 3'b000, 1'b0, 4'hF, A0, W0, D0));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, A0, Z, Z, 4'b0000, 4'b0000, 3'b000, 3'b000, 1'b0, 4'hF, A0, W0, D0));
        vq.push_back(idle(3'b000, 3'b000, 3'b000, Z, Z, Z));

        foreach (vq[i]) begin
            drive(vq[i].cyc, vq[i].stb, vq[i].we, vq[i].a0, vq[i].a1, vq[i].a2, vq[i].sack);
            @(negedge sys_clk);
            chk($sformatf("vec%0d", i), outs(),
                {vq[i].e_ack, vq[i].e_err, vq[i].e_stb, vq[i].e_we, vq[i].e_sel,
                 vq[i].e_addr, vq[i].e_wdata, vq[i].e_rdata});
            step();
        end

        // Abort: m0 drops cyc before ack; late acks must not reach the master.
        drive(3'b001, 3'b001, 3'b000, AS, Z, Z, 4'h0);
        step();
        @(negedge sys_clk);
        chk("abort_busy_stb", {m_ack_o, s_stb_o}, {3'b000, 4'b0010});
        step();
        drive(3'b000, 3'b000, 3'b000, AS, Z, Z, 4'b0010);
        @(negedge sys_clk);
        chk("abort_drop_cycle", {m_ack_o, m_err_o, s_stb_o}, {3'b000, 3'b000, 4'b0000});
        step();
        @(negedge sys_clk);
        chk("abort_late_ack", outs(), '0);
        step();
        drive(3'b000, 3'b000, 3'b000, Z, Z, Z, 4'h0);
        step();

        // Asynchronous reset in the middle of a BUSY transfer.
        drive(3'b010, 3'b010, 3'b000, Z, B, Z, 4'h0);
        step();
        @(negedge sys_clk);
        chk("rst_busy_stb", {s_stb_o, s_addr_o}, {4'b1000, B});
        sys_rst = 1'b0;
        #1;
        chk("rst_async_outputs", outs(), '0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        chk("rst_idle_after", outs(), '0);
        step();
        @(negedge sys_clk);
        chk("rst_regrant_m1", {m_ack_o, s_stb_o}, {3'b000, 4'b1000});
        step();
        drive(3'b000, 3'b000, 3'b000, Z, Z, Z, 4'h0);
        step();
        step();

        // Stalled slave: timeout pulse at the 8th stalled cycle when enabled.
        drive(3'b100, 3'b100, 3'b000, Z, Z, 32'h2000_0000, 4'h0);
        step();
        for (int n = 1; n <= 10; n++) begin
            @(negedge sys_clk);
            e_stb = 4'b0100;
            e_err = 3'b000;
            if (TO_EN && n == 8) begin
                e_stb = 4'b0000;
                e_err = 3'b100;
            end
            chk($sformatf("stall_cycle%0d", n), {m_ack_o, m_err_o, s_stb_o}, {3'b000, e_err, e_stb});
            step();
        end
        drive(3'b000, 3'b000, 3'b000, Z, Z, Z, 4'h0);
        step();
        @(negedge sys_clk);
        chk("stall_released", outs(), '0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_xbar_rr.md
Name: wb_xbar_rr

Overview:
- Parametrised Wishbone shared-bus interconnect.
- Replaces the fixed-topology communication hub between bus masters (CPU instruction port, CPU data port, DMA) and slaves (ROM, RAM ports, IO).
- NM masters are arbitrated round-robin onto one shared bus; the granted master's address is decoded to one of NS slaves via a parametrised base/mask map.
- Adds bus locking for back-to-back transfers, byte selects and error response for unmapped addresses.

Parameters:
- NM, 3, number of masters (2..8).
- NS, 4, number of slaves (1..8).
- AW, 32, address width.
- DW, 32, data width (multiple of 8); SW = DW/8.
- SLV_BASE, {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, packed NS*AW; slave i base at bits [i*AW +: AW].
- SLV_MASK, {4{32'hF000_0000}}, packed NS*AW; slave i hits when (addr & mask_i) == base_i.
- TIMEOUT, 255, cycles without ack before error (optional feature only).

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  asynchronous, active-low reset.
- m_cyc_i  in  NM  master cycle.
- m_stb_i  in  NM  master strobe.
- m_we_i  in  NM  master write enable.
- m_sel_i  in  NM*SW  master byte selects.
- m_addr_i  in  NM*AW  master addresses.
- m_data_i  in  NM*DW  master write data.
- m_ack_o  out  NM  ack, granted master only.
- m_err_o  out  NM  error, granted master only.
- m_data_o  out  DW  read data, broadcast to all masters.
- s_stb_o  out  NS  one-hot slave strobe.
- s_we_o  out  1  shared write enable.
- s_sel_o  out  SW  shared byte selects.
- s_addr_o  out  AW  shared address.
- s_data_o  out  DW  shared write data.
- s_ack_i  in  NS  slave acks.
- s_data_i  in  NS*DW  slave read data.

Behaviour:
- Reset (sys_rst=0, async): state=IDLE, grant=0, last=NM-1. All outputs 0: m_ack_o, m_err_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o, m_data_o.
- States: IDLE, BUSY.
- IDLE:
  - req[i] = m_cyc_i[i] & m_stb_i[i].
  - If any req, pick the first requesting index scanning last+1, last+2, … mod NM. Register it as grant and go to BUSY.
  - No slave strobe is issued in IDLE.
  - Arbitration latency: 1 cycle (request at cycle 0, slave stb at cycle 1).
- BUSY:
  - Shared slave signals mux combinationally from master[grant].
  - Decode: hit[i] per the SLV_BASE/SLV_MASK rule. On overlap, the lowest index wins.
  - s_stb_o[i] = m_stb_i[grant] & hit[i].
  - m_ack_o[grant] = s_ack_i[sel]; m_data_o = s_data_i[sel] (combinational, zero added latency). m_data_o = 0 when no slave is selected.
  - Unmapped address with stb: m_err_o[grant]=1 in that same cycle, no slave strobed (internal default slave).
  - Lock: grant holds while m_cyc_i[grant]=1, so consecutive stb/ack transfers are uninterrupted.
  - m_cyc_i[grant] falls: state becomes IDLE, last=grant, bus outputs return to 0 next cycle.
- Other masters' ack/err are always 0.
- Acks from non-selected slaves are ignored.
- Simultaneous requests: round-robin only. No master wins twice in a row while another requests at release.
- Master drops cyc mid-transfer (before ack): abort. Stb dropped the same cycle, next cycle IDLE; a late slave ack is ignored.
- Mid-operation reset returns immediately to reset values.
- last pointer wraps NM-1 to 0.

Optional Feature:
- Macro WB_XBAR_TIMEOUT_EN.
- Defined: an 8..16-bit counter clears on ack/err or stb=0 and increments each BUSY cycle with stb high and no ack. On reaching TIMEOUT:
  - m_err_o[grant] pulses for 1 cycle.
  - s_stb_o is forced 0 for that cycle.
  - The counter clears; the lock is kept.
- Undefined: no counter; a stalled slave hangs the bus indefinitely.

Decomposition:
- Package wb_xbar_pkg:
  - state enum (IDLE, BUSY);
  - default map localparams (ROM_BASE, RAM_BASE, RAM2_BASE, IO_BASE, REGION_MASK);
  - function addr_hit(addr, base, mask).
- Sub-module wb_rr_arbiter: NM-bit req in, last pointer, one-hot/indexed grant out. Combinational plus pointer register; reused later by DMA channels.

Test Plan:
- Single master: m0 reads 0x1000_0010 → s_stb_o=4'b0010 at cycle 1; slave acks cycle 3 with 0xDEAD_BEEF → m_ack_o=3'b001 and m_data_o=0xDEAD_BEEF in cycle 3.
- Contention: m0, m1, m2 request together continuously, each releasing after 1 transfer → grant order 0,1,2,0.
- Lock: m1 holds cyc over 4 writes to 0x3000_0000..0C with sel=4'b0011 → all 4 acked to m1. m0, requesting throughout, is granted only after m1 drops cyc.
- Unmapped: m2 with mask altered so 0xF000_0000 misses, stb → m_err_o=3'b100 same cycle, s_stb_o=0.
- Abort/reset: m0 drops cyc before ack → IDLE next cycle and a late ack produces no m_ack_o. Asserting sys_rst=0 mid-BUSY → all outputs 0 immediately.
- WB_XBAR_TIMEOUT_EN with TIMEOUT=8: slave never acks → m_err_o pulses at the 8th stalled cycle and s_stb_o drops that cycle.
